// File: rtl/lcd_sequencer_if.sv
// Byte-write handshake between lcd_sequencer (master) and the character-LCD
// write controller (slave).
interface lcd_sequencer_if;
  logic [7:0] lcdData;
  logic       lcdRs;
  logic       lcdStart;
  logic       lcdReset;
  logic       lcdDone;

  modport master (output lcdData, output lcdRs, output lcdStart, output lcdReset, input lcdDone);
  modport slave  (input lcdData, input lcdRs, input lcdStart, input lcdReset, output lcdDone);
endinterface

// File: rtl/lcd_sequencer.sv
// HD44780 init sequencer and 2x16 repaint engine driving a one-byte-per-handshake
// LCD write controller from a host-written 32-byte character buffer.
module lcd_sequencer #(
  parameter int PWR_WAIT = 16,
  parameter int CMD_WAIT = 4,
  parameter int CLR_WAIT = 8,
  parameter int TIMEOUT  = 64
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iWR,
  input  logic [4:0]      iADDR,
  input  logic [7:0]      iWDATA,
  input  logic            iRefresh,
  output logic            oBusy,
  output logic            oReady,
  output logic            oError,
  lcd_sequencer_if.master lcd
);

  localparam logic [2:0] RST_LCD = 3'd0;
  localparam logic [2:0] PWR     = 3'd1;
  localparam logic [2:0] LOAD    = 3'd2;
  localparam logic [2:0] START   = 3'd3;
  localparam logic [2:0] ACK_LO  = 3'd4;
  localparam logic [2:0] ACK_HI  = 3'd5;
  localparam logic [2:0] GAP     = 3'd6;
  localparam logic [2:0] IDLE    = 3'd7;

  logic [2:0]  state;
  logic [5:0]  step;
  logic [15:0] waitCnt;
  logic        pending;
  logic [7:0]  dataQ;
  logic        rsQ;
  logic [7:0]  charBuf [32];

  logic [5:0]  loadStep;
  logic [4:0]  line1Idx;
  logic [4:0]  line2Idx;
  logic [7:0]  loadData;
  logic        loadRs;
  logic [15:0] gapLast;
  logic        ackExpired;

  // The character buffer is writable every cycle regardless of what the FSM is doing.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int i = 0; i < 32; i++) charBuf[i] <= 8'h20;
    end else if (iWR) begin
      charBuf[iADDR] <= iWDATA;
    end
  end

  // Byte for the step about to enter LOAD; it is latched on that transition so the
  // bus holds still until GAP exits, and a same-cycle write is seen only next time.
  always_comb begin
    case (state)
      PWR:     loadStep = 6'd0;
      IDLE:    loadStep = 6'd4;
      default: loadStep = step + 6'd1;
    endcase
  end

  assign line1Idx = 5'(loadStep - 6'd5);
  assign line2Idx = 5'(loadStep - 6'd6);

  always_comb begin
    loadData = 8'h00;
    loadRs   = 1'b0;
    case (loadStep)
      6'd0:  loadData = 8'h38;
      6'd1:  loadData = 8'h0C;
      6'd2:  loadData = 8'h01;
      6'd3:  loadData = 8'h06;
      6'd4:  loadData = 8'h80;
      6'd21: loadData = 8'hC0;
      default: begin
        loadRs   = 1'b1;
        loadData = (loadStep < 6'd21) ? charBuf[line1Idx] : charBuf[line2Idx];
      end
    endcase
  end

  assign gapLast    = (step == 6'd2) ? 16'(CLR_WAIT - 1) : 16'(CMD_WAIT - 1);
  assign ackExpired = (waitCnt == 16'(TIMEOUT - 1));

  // Main sequencer; waitCnt is zeroed on every transition so each phase counts from 0.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state   <= RST_LCD;
      step    <= 6'd0;
      waitCnt <= 16'd0;
      pending <= 1'b0;
      oReady  <= 1'b0;
      oError  <= 1'b0;
      dataQ   <= 8'h00;
      rsQ     <= 1'b0;
    end else begin
      if (iRefresh && state != IDLE) pending <= 1'b1;
      case (state)
        RST_LCD: begin
          state   <= PWR;
          waitCnt <= 16'd0;
        end
        PWR: begin
          if (waitCnt == 16'(PWR_WAIT - 1)) begin
            state   <= LOAD;
            step    <= 6'd0;
            waitCnt <= 16'd0;
            dataQ   <= loadData;
            rsQ     <= loadRs;
          end else begin
            waitCnt <= waitCnt + 16'd1;
          end
        end
        LOAD: state <= START;
        START: begin
          state   <= ACK_LO;
          waitCnt <= 16'd0;
        end
        ACK_LO: begin
          if (!lcd.lcdDone) begin
            state   <= ACK_HI;
            waitCnt <= 16'd0;
          end else if (ackExpired) begin
            state   <= RST_LCD;
            waitCnt <= 16'd0;
            oError  <= 1'b1;
            oReady  <= 1'b0;
          end else begin
            waitCnt <= waitCnt + 16'd1;
          end
        end
        ACK_HI: begin
          if (lcd.lcdDone) begin
            state   <= GAP;
            waitCnt <= 16'd0;
          end else if (ackExpired) begin
            state   <= RST_LCD;
            waitCnt <= 16'd0;
            oError  <= 1'b1;
            oReady  <= 1'b0;
          end else begin
            waitCnt <= waitCnt + 16'd1;
          end
        end
        GAP: begin
          if (waitCnt == gapLast) begin
            waitCnt <= 16'd0;
            if (step == 6'd3) begin
              oReady <= 1'b1;
              state  <= IDLE;
            end else if (step == 6'd37) begin
              state <= IDLE;
            end else begin
              step  <= step + 6'd1;
              state <= LOAD;
              dataQ <= loadData;
              rsQ   <= loadRs;
            end
          end else begin
            waitCnt <= waitCnt + 16'd1;
          end
        end
        IDLE: begin
          if (pending || iRefresh) begin
            pending <= 1'b0;
            step    <= 6'd4;
            state   <= LOAD;
            dataQ   <= loadData;
            rsQ     <= loadRs;
          end
        end
        default: state <= RST_LCD;
      endcase
    end
  end

  assign oBusy        = (state != IDLE);
  assign lcd.lcdData  = dataQ;
  assign lcd.lcdRs    = rsQ;
  assign lcd.lcdStart = (state == START) || (state == ACK_LO) || (state == ACK_HI);
  assign lcd.lcdReset = (state == RST_LCD);

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed bench for lcd_sequencer with an 18-cycle LCD write-controller model.
module tb_lcd_sequencer;

  localparam int HS_CYC = 18;

  logic       iCLK;
  logic       iRST;
  logic       iWR;
  logic [4:0] iADDR;
  logic [7:0] iWDATA;
  logic       iRefresh;
  logic       oBusy;
  logic       oReady;
  logic       oError;

  lcd_sequencer_if lcdBus ();

  lcd_sequencer dut (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iWR      (iWR),
    .iADDR    (iADDR),
    .iWDATA   (iWDATA),
    .iRefresh (iRefresh),
    .oBusy    (oBusy),
    .oReady   (oReady),
    .oError   (oError),
    .lcd      (lcdBus)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Controller model: done drops when start rises and returns HS_CYC cycles later.
  logic doneQ = 1'b1;
  logic startQ = 1'b0;
  logic forceLow = 1'b0;
  int   hsCnt = 0;
  assign lcdBus.lcdDone = doneQ;

  always @(posedge iCLK) begin
    startQ <= lcdBus.lcdStart;
    if (forceLow) begin
      doneQ <= 1'b0;
      hsCnt <= 0;
    end else if (lcdBus.lcdStart && !startQ) begin
      doneQ <= 1'b0;
      hsCnt <= HS_CYC;
    end else if (hsCnt != 0) begin
      hsCnt <= hsCnt - 1;
      if (hsCnt == 1) doneQ <= 1'b1;
    end
  end

  int         errors = 0;
  int         checks = 0;
  int         lowRun;
  int         highRun;
  int         curIdx;
  logic [7:0] capData;
  logic       capRs;
  logic [7:0] expBuf [32];
  logic [7:0] lastPaint [34];
  int         hookKind [34];
  logic [4:0] hookAddr [34];
  logic [7:0] hookData [34];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle drive of the host inputs, starting at the current falling edge.
  task automatic applyStimulus(input logic wr, input logic [4:0] addr, input logic [7:0] data,
                               input logic refresh);
    iWR = wr; iADDR = addr; iWDATA = data; iRefresh = refresh;
    if (wr) expBuf[addr] = data;
    @(negedge iCLK);
    iWR = 1'b0; iRefresh = 1'b0;
  endtask

  task automatic clearHooks();
    for (int i = 0; i < 34; i++) hookKind[i] = 0;
  endtask

  task automatic waitRise(input string tag);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge iCLK);
      if (lcdBus.lcdStart) begin
        seen = 1'b1;
        break;
      end
      lowRun++;
    end
    capData = lcdBus.lcdData;
    capRs   = lcdBus.lcdRs;
    checkOutput({tag, " start rise"}, 32'(seen), 32'd1);
  endtask

  task automatic waitFall(input string tag);
    logic seen;
    logic stable;
    seen = 1'b0; stable = 1'b1; highRun = 1;
    for (int n = 0; n < 400; n++) begin
      @(negedge iCLK);
      iWR = 1'b0; iRefresh = 1'b0;
      if (n == 0 && curIdx >= 0) begin
        if (hookKind[curIdx] == 1) begin
          iWR = 1'b1; iADDR = hookAddr[curIdx]; iWDATA = hookData[curIdx];
          expBuf[hookAddr[curIdx]] = hookData[curIdx];
        end else if (hookKind[curIdx] == 2) begin
          iRefresh = 1'b1;
        end
      end
      if (!lcdBus.lcdStart) begin
        seen = 1'b1;
        break;
      end
      highRun++;
      if (lcdBus.lcdData !== capData || lcdBus.lcdRs !== capRs) stable = 1'b0;
    end
    iWR = 1'b0; iRefresh = 1'b0;
    lowRun = 1;
    checkOutput({tag, " start fall"}, 32'(seen), 32'd1);
    checkOutput({tag, " data stable"}, 32'(stable), 32'd1);
  endtask

  task automatic runInit(input string tag);
    logic [7:0] cmd [4];
    int         gapLow [4];
    cmd = '{8'h38, 8'h0C, 8'h01, 8'h06};
    gapLow = '{17, 5, 5, 9};
    curIdx = -1;
    for (int i = 0; i < 4; i++) begin
      waitRise(tag);
      checkOutput($sformatf("%s cmd%0d low cycles", tag, i), 32'(lowRun), 32'(gapLow[i]));
      checkOutput($sformatf("%s cmd%0d data", tag, i), 32'(capData), 32'(cmd[i]));
      checkOutput($sformatf("%s cmd%0d rs", tag, i), 32'(capRs), 32'd0);
      waitFall(tag);
    end
    repeat (3) @(negedge iCLK);
    checkOutput({tag, " busy in last gap"}, 32'(oBusy), 32'd1);
    checkOutput({tag, " ready in last gap"}, 32'(oReady), 32'd0);
    @(negedge iCLK);
    checkOutput({tag, " busy after init"}, 32'(oBusy), 32'd0);
    checkOutput({tag, " ready after init"}, 32'(oReady), 32'd1);
  endtask

  task automatic collectRepaint(input string tag);
    logic [7:0] expData;
    logic       expRs;
    for (int k = 0; k < 34; k++) begin
      curIdx = k;
      waitRise(tag);
      if (k == 0)       begin expData = 8'h80;          expRs = 1'b0; end
      else if (k < 17)  begin expData = expBuf[k - 1];  expRs = 1'b1; end
      else if (k == 17) begin expData = 8'hC0;          expRs = 1'b0; end
      else              begin expData = expBuf[k - 2];  expRs = 1'b1; end
      lastPaint[k] = capData;
      checkOutput($sformatf("%s byte%0d data", tag, k), 32'(capData), 32'(expData));
      checkOutput($sformatf("%s byte%0d rs", tag, k), 32'(capRs), 32'(expRs));
      waitFall(tag);
    end
    curIdx = -1;
  endtask

  task automatic waitIdle(input string tag);
    for (int n = 0; n < 50 && oBusy; n++) @(negedge iCLK);
    checkOutput({tag, " idle"}, 32'(oBusy), 32'd0);
  endtask

  initial begin
    int rises;
    iRST = 1'b1; iWR = 1'b0; iADDR = 5'd0; iWDATA = 8'h00; iRefresh = 1'b0;
    curIdx = -1; lowRun = 0; highRun = 0;
    for (int i = 0; i < 32; i++) expBuf[i] = 8'h20;
    clearHooks();

    repeat (3) @(negedge iCLK);
    checkOutput("reset busy", 32'(oBusy), 32'd1);
    checkOutput("reset ready", 32'(oReady), 32'd0);
    checkOutput("reset error", 32'(oError), 32'd0);
    checkOutput("reset start", 32'(lcdBus.lcdStart), 32'd0);
    checkOutput("reset data", 32'(lcdBus.lcdData), 32'h00);
    checkOutput("reset rs", 32'(lcdBus.lcdRs), 32'd0);
    checkOutput("reset lcdReset", 32'(lcdBus.lcdReset), 32'd1);
    iRST = 1'b0;
    @(negedge iCLK);
    checkOutput("lcdReset single pulse", 32'(lcdBus.lcdReset), 32'd0);
    lowRun = 1;
    runInit("init");

    $display("[TB] full repaint");
    applyStimulus(1'b1, 5'd0, "H", 1'b0);
    applyStimulus(1'b1, 5'd1, "E", 1'b0);
    applyStimulus(1'b1, 5'd2, "L", 1'b0);
    applyStimulus(1'b1, 5'd3, "L", 1'b0);
    applyStimulus(1'b1, 5'd4, "O", 1'b0);
    applyStimulus(1'b1, 5'd16, "W", 1'b0);
    applyStimulus(1'b0, 5'd0, 8'h00, 1'b1);
    collectRepaint("paint");
    checkOutput("paint H", 32'(lastPaint[1]), 32'h48);
    checkOutput("paint W", 32'(lastPaint[18]), 32'h57);
    waitIdle("paint");

    $display("[TB] request merging");
    hookKind[3] = 2; hookKind[10] = 2; hookKind[20] = 2;
    applyStimulus(1'b0, 5'd0, 8'h00, 1'b1);
    collectRepaint("merge first");
    clearHooks();
    collectRepaint("merge second");
    waitIdle("merge");
    rises = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge iCLK);
      if (lcdBus.lcdStart) rises++;
    end
    checkOutput("merge no third repaint", 32'(rises), 32'd0);

    $display("[TB] late write");
    hookKind[10] = 1; hookAddr[10] = 5'd31; hookData[10] = "Z";
    hookKind[12] = 1; hookAddr[12] = 5'd0;  hookData[12] = "J";
    applyStimulus(1'b0, 5'd0, 8'h00, 1'b1);
    collectRepaint("late");
    clearHooks();
    checkOutput("late Z in same paint", 32'(lastPaint[33]), 32'h5A);
    checkOutput("late addr0 old value", 32'(lastPaint[1]), 32'h48);
    waitIdle("late");
    applyStimulus(1'b0, 5'd0, 8'h00, 1'b1);
    collectRepaint("late next");
    checkOutput("late addr0 next paint", 32'(lastPaint[1]), 32'h4A);
    waitIdle("late next");

    $display("[TB] handshake timeout");
    forceLow = 1'b1;
    applyStimulus(1'b0, 5'd0, 8'h00, 1'b1);
    curIdx = -1;
    waitRise("timeout");
    waitFall("timeout");
    checkOutput("timeout start-high cycles", 32'(highRun), 32'd66);
    checkOutput("timeout error", 32'(oError), 32'd1);
    checkOutput("timeout ready", 32'(oReady), 32'd0);
    checkOutput("timeout start", 32'(lcdBus.lcdStart), 32'd0);
    checkOutput("timeout lcdReset", 32'(lcdBus.lcdReset), 32'd1);
    forceLow = 1'b0;
    lowRun = 0;
    runInit("reinit");
    checkOutput("error sticky", 32'(oError), 32'd1);
    applyStimulus(1'b0, 5'd0, 8'h00, 1'b1);
    collectRepaint("kept buffer");
    waitIdle("kept buffer");

    $display("[TB] mid-operation reset");
    applyStimulus(1'b0, 5'd0, 8'h00, 1'b1);
    curIdx = -1;
    waitRise("midrst");
    waitFall("midrst");
    waitRise("midrst char");
    checkOutput("midrst char rs", 32'(capRs), 32'd1);
    iRST = 1'b1;
    @(negedge iCLK);
    checkOutput("midrst start", 32'(lcdBus.lcdStart), 32'd0);
    checkOutput("midrst error", 32'(oError), 32'd0);
    checkOutput("midrst ready", 32'(oReady), 32'd0);
    checkOutput("midrst lcdReset", 32'(lcdBus.lcdReset), 32'd1);
    iRST = 1'b0;
    for (int i = 0; i < 32; i++) expBuf[i] = 8'h20;
    lowRun = 0;
    runInit("rerun init");
    applyStimulus(1'b0, 5'd0, 8'h00, 1'b1);
    collectRepaint("blank");
    waitIdle("blank");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
